// File: rtl/mem_pkg.sv
// Shared types for the MEM/WB stage: funct3 codes, FSM states and the
// write-back bundle.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  localparam int WB_XMAX = 64;
  localparam int WB_RMAX = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Sized for the widest build; narrower builds use the low bits.
  typedef struct packed {
    logic               reg_write;
    logic [WB_RMAX-1:0] rd_addr;
    logic [WB_XMAX-1:0] rd_data;
  } wb_t;

endpackage

// File: rtl/mem_wb_stage_load_extract.sv
// Load data extraction: lane shift by byte offset, then sign/zero
// extension chosen by funct3.
module load_extract
  import mem_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OW   = $clog2(XLEN/8)
) (
  input  logic [XLEN-1:0] i_data,
  input  logic [OW-1:0]   i_off,
  input  logic [2:0]      i_f3,
  output logic [XLEN-1:0] o_data
);

  logic [XLEN-1:0] w_sh;

  assign w_sh = i_data >> {i_off, 3'b000};

  always_comb begin
    o_data = XLEN'(w_sh[15:0]);
    unique case (i_f3)
      F3_LB:  o_data = XLEN'($signed(w_sh[7:0]));
      F3_LBU: o_data = XLEN'(w_sh[7:0]);
      F3_LH:  o_data = XLEN'($signed(w_sh[15:0]));
      F3_LHU: o_data = XLEN'(w_sh[15:0]);
      F3_LW:  o_data = XLEN'($signed(w_sh[31:0]));
      F3_LWU: begin
        if (XLEN == 64) o_data = XLEN'(w_sh[31:0]);
      end
      F3_LD: begin
        if (XLEN == 64) o_data = w_sh;
      end
      default: o_data = XLEN'(w_sh[15:0]);
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: req/ack data-memory port, load extraction, registered
// write-back. Optional misaligned-access trap: MEMWB_MISALIGN_TRAP_EN.
module mem_wb_stage
  import mem_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_ADDR = 5,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic                reg_write,
  input  logic                mem_to_reg,
  input  logic                rd_src,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     alu_out,
  input  logic [XLEN-1:0]     pc_to_reg,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [REG_ADDR-1:0] rd_addr,
  output logic                dm_req,
  output logic [XLEN/8-1:0]   dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [XLEN-1:0]     dm_wdata,
  input  logic                dm_ack,
  input  logic [XLEN-1:0]     dm_rdata,
  output logic                wb_valid,
  output logic                wb_reg_write,
  output logic [REG_ADDR-1:0] wb_rd_addr,
  output logic [XLEN-1:0]     wb_rd_data,
  output logic [XLEN-1:0]     fwd_rd_data,
  output logic                bus_err,
  output logic                misalign
);

  localparam int NB = XLEN/8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT+1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [OW-1:0]   r_off;
  logic [2:0]      r_f3;
  logic            r_m2r;
  wb_t             r_op;
  wb_t             r_wb;

  logic            w_acc;
  logic            w_mem;
  logic            w_mis;
  logic            w_trap;
  logic            w_go_mem;
  logic            w_tmo;
  logic [OW-1:0]   w_off;
  logic [OW-1:0]   w_mask;
  logic [OW-1:0]   w_off_al;
  logic [NB-1:0]   w_strb;
  logic [XLEN-1:0] w_ld;
  logic            w_unused;

  assign fwd_rd_data = rd_src ? pc_to_reg : alu_out;
  assign in_ready    = (r_state == S_IDLE);
  assign w_acc       = in_valid & in_ready & ~flush;
  assign w_mem       = mem_read | mem_write;
  assign w_off       = alu_out[OW-1:0];

  // Offset bits inside the access size: misalignment source,
  // and cleared to force natural alignment.
  always_comb begin
    w_mask = '0;
    w_strb = '1;
    unique case (1'b1)
      funct3[1:0] == 2'b00: begin
        w_mask = '0;
        w_strb = NB'(1);
      end
      funct3[1:0] == 2'b01: begin
        w_mask = OW'(1);
        w_strb = NB'(3);
      end
      funct3[1:0] == 2'b10: begin
        w_mask = OW'(3);
        w_strb = NB'(15);
      end
      default: begin
        w_mask = '1;
        w_strb = '1;
      end
    endcase
  end

  assign w_mis    = |(w_off & w_mask);
  assign w_off_al = w_off & ~w_mask;

`ifdef MEMWB_MISALIGN_TRAP_EN
  assign w_trap = w_mis;
`else
  assign w_trap = 1'b0;
`endif

  assign w_go_mem = w_acc & w_mem & ~w_trap;
  assign w_tmo    = (r_state == S_WAIT) & ~dm_ack
                  & (r_cnt == CW'(TIMEOUT-1));

  load_extract #(
    .XLEN (XLEN)
  ) u_ld (
    .i_data (dm_rdata),
    .i_off  (r_off),
    .i_f3   (r_f3),
    .o_data (w_ld)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_go_mem) w_next = S_WAIT;
      S_WAIT:  if (dm_ack | w_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dm_req   <= 1'b0;
      dm_we    <= '0;
      dm_addr  <= '0;
      dm_wdata <= '0;
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      r_wb     <= '0;
      r_op     <= '0;
      r_cnt    <= '0;
      r_off    <= '0;
      r_f3     <= '0;
      r_m2r    <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      bus_err  <= 1'b0;
      if (w_acc & ~w_go_mem) begin
        wb_valid <= 1'b1;
        r_wb <= '{reg_write: reg_write & ~w_mem,
                  rd_addr:   WB_RMAX'(rd_addr),
                  rd_data:   WB_XMAX'(fwd_rd_data)};
      end
      if (w_go_mem) begin
        dm_req   <= 1'b1;
        dm_we    <= mem_write ? (w_strb << w_off_al) : '0;
        dm_addr  <= ADDR_W'(alu_out) & ~ADDR_W'(NB-1);
        dm_wdata <= rs2_data << {w_off_al, 3'b000};
        r_op <= '{reg_write: reg_write & ~mem_write,
                  rd_addr:   WB_RMAX'(rd_addr),
                  rd_data:   WB_XMAX'(fwd_rd_data)};
        r_off    <= w_off_al;
        r_f3     <= funct3;
        r_m2r    <= mem_to_reg;
        r_cnt    <= '0;
      end
      if (r_state == S_WAIT) begin
        if (dm_ack) begin
          dm_req   <= 1'b0;
          dm_we    <= '0;
          wb_valid <= 1'b1;
          r_wb.reg_write <= r_op.reg_write;
          r_wb.rd_addr   <= r_op.rd_addr;
          r_wb.rd_data   <= r_m2r ? WB_XMAX'(w_ld)
                                  : r_op.rd_data;
        end else if (w_tmo) begin
          dm_req  <= 1'b0;
          dm_we   <= '0;
          bus_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

`ifdef MEMWB_MISALIGN_TRAP_EN
  logic r_mis;

  always_ff @(posedge clk) begin
    if (!rst) r_mis <= 1'b0;
    else      r_mis <= w_acc & w_mem & w_mis;
  end

  assign misalign = r_mis;
`else
  assign misalign = 1'b0;
`endif

  assign wb_reg_write = r_wb.reg_write;
  assign wb_rd_addr   = r_wb.rd_addr[REG_ADDR-1:0];
  assign wb_rd_data   = r_wb.rd_data[XLEN-1:0];

  // Upper bundle bits are only live in wide builds.
  assign w_unused = ^{r_wb, r_op, w_mis};

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: 32-bit and 64-bit instances,
// ALU, store, load, timeout and reset-in-WAIT cases.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          nvec = 0;
  int          nfail = 0;

  logic        in_valid, in_ready, flush;
  logic        mem_read, mem_write, reg_write, mem_to_reg, rd_src;
  logic [2:0]  funct3;
  logic [31:0] alu_out, pc_to_reg, rs2_data;
  logic [4:0]  rd_addr;
  logic        dm_req, dm_ack;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        wb_valid, wb_reg_write, bus_err, misalign;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data, fwd_rd_data;

  logic        x_in_valid, x_in_ready, x_flush;
  logic        x_mem_read, x_mem_write, x_reg_write;
  logic        x_mem_to_reg, x_rd_src;
  logic [2:0]  x_funct3;
  logic [63:0] x_alu_out, x_pc_to_reg, x_rs2_data;
  logic [4:0]  x_rd_addr;
  logic        x_dm_req, x_dm_ack;
  logic [7:0]  x_dm_we;
  logic [31:0] x_dm_addr;
  logic [63:0] x_dm_wdata, x_dm_rdata;
  logic        x_wb_valid, x_wb_reg_write, x_bus_err, x_misalign;
  logic [4:0]  x_wb_rd_addr;
  logic [63:0] x_wb_rd_data, x_fwd_rd_data;

  always #5 clk = ~clk;

  mem_wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .rd_src(rd_src), .funct3(funct3), .alu_out(alu_out),
    .pc_to_reg(pc_to_reg), .rs2_data(rs2_data),
    .rd_addr(rd_addr), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack),
    .dm_rdata(dm_rdata), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr),
    .wb_rd_data(wb_rd_data), .fwd_rd_data(fwd_rd_data),
    .bus_err(bus_err), .misalign(misalign)
  );

  mem_wb_stage #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(x_in_valid), .in_ready(x_in_ready), .flush(x_flush),
    .mem_read(x_mem_read), .mem_write(x_mem_write),
    .reg_write(x_reg_write), .mem_to_reg(x_mem_to_reg),
    .rd_src(x_rd_src), .funct3(x_funct3), .alu_out(x_alu_out),
    .pc_to_reg(x_pc_to_reg), .rs2_data(x_rs2_data),
    .rd_addr(x_rd_addr), .dm_req(x_dm_req), .dm_we(x_dm_we),
    .dm_addr(x_dm_addr), .dm_wdata(x_dm_wdata), .dm_ack(x_dm_ack),
    .dm_rdata(x_dm_rdata), .wb_valid(x_wb_valid),
    .wb_reg_write(x_wb_reg_write), .wb_rd_addr(x_wb_rd_addr),
    .wb_rd_data(x_wb_rd_data), .fwd_rd_data(x_fwd_rd_data),
    .bus_err(x_bus_err), .misalign(x_misalign)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic rd, input logic wr, input logic rw,
                    input logic m2r, input logic rs, input logic [2:0] f3,
                    input logic [31:0] alu, input logic [31:0] pc,
                    input logic [31:0] rs2, input logic [4:0] rdx);
    in_valid   = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    reg_write  = rw;
    mem_to_reg = m2r;
    rd_src     = rs;
    funct3     = f3;
    alu_out    = alu;
    pc_to_reg  = pc;
    rs2_data   = rs2;
    rd_addr    = rdx;
  endtask

  initial begin
    int n;
    in_valid = 0; flush = 0; mem_read = 0; mem_write = 0;
    reg_write = 0; mem_to_reg = 0; rd_src = 0; funct3 = 0;
    alu_out = 0; pc_to_reg = 0; rs2_data = 0; rd_addr = 0;
    dm_ack = 0; dm_rdata = 0;
    x_in_valid = 0; x_flush = 0; x_mem_read = 0; x_mem_write = 0;
    x_reg_write = 0; x_mem_to_reg = 0; x_rd_src = 0; x_funct3 = 0;
    x_alu_out = 0; x_pc_to_reg = 0; x_rs2_data = 0; x_rd_addr = 0;
    x_dm_ack = 0; x_dm_rdata = 0;

    tick(); tick();
    chk("rst_dm_req", dm_req, 0);
    chk("rst_dm_we", dm_we, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_data", wb_rd_data, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // ALU ops back to back
    op(0, 0, 1, 0, 0, 3'b000, 32'h1234, 32'h4444, 0, 5'd5);
    #1 chk("fwd_alu", fwd_rd_data, 32'h1234);
    tick();
    chk("alu_wb_valid", wb_valid, 1);
    chk("alu_wb_rd", wb_rd_addr, 5);
    chk("alu_wb_data", wb_rd_data, 32'h1234);
    chk("alu_wb_we", wb_reg_write, 1);
    op(0, 0, 1, 0, 1, 3'b000, 32'h1234, 32'h4444, 0, 5'd6);
    tick();
    chk("alu2_wb_valid", wb_valid, 1);
    chk("alu2_wb_rd", wb_rd_addr, 6);
    chk("alu2_wb_data", wb_rd_data, 32'h4444);
    flush = 1'b1;
    tick();
    chk("flush_wb_valid", wb_valid, 0);
    flush = 1'b0;
    in_valid = 1'b0;

    // SB at 0x103 with three ack-less wait cycles
    op(0, 1, 0, 0, 0, 3'b000, 32'h103, 0, 32'hAB, 5'd1);
    tick();
    in_valid = 1'b0;
    chk("sb_wdata", dm_wdata, 32'hAB00_0000);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req_held", dm_req, 1);
      chk("sb_we_held", dm_we, 4'b1000);
      chk("sb_addr_held", dm_addr, 32'h100);
      chk("sb_in_ready", in_ready, 0);
      tick();
    end
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("sb_wb_valid", wb_valid, 1);
    chk("sb_wb_we", wb_reg_write, 0);
    chk("sb_req_drop", dm_req, 0);
    chk("sb_in_ready_back", in_ready, 1);

    // LB at 0x102, ack after one wait cycle
    op(1, 0, 1, 1, 0, 3'b000, 32'h102, 0, 0, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("lb_req", dm_req, 1);
    chk("lb_we", dm_we, 0);
    chk("lb_addr", dm_addr, 32'h100);
    tick();
    dm_ack = 1'b1;
    dm_rdata = 32'h0080_0000;
    tick();
    dm_ack = 1'b0;
    chk("lb_wb_valid", wb_valid, 1);
    chk("lb_wb_data", wb_rd_data, 32'hFFFF_FF80);
    chk("lb_wb_rd", wb_rd_addr, 7);

    // LBU, ack in the first wait cycle
    op(1, 0, 1, 1, 0, 3'b100, 32'h102, 0, 0, 5'd8);
    tick();
    in_valid = 1'b0;
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("lbu_wb_valid", wb_valid, 1);
    chk("lbu_wb_data", wb_rd_data, 32'h0000_0080);

    // LW at 0x102 is truncated to an aligned word
    op(1, 0, 1, 1, 0, 3'b010, 32'h102, 0, 0, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("lw_mis_req", dm_req, 1);
    chk("lw_mis_addr", dm_addr, 32'h100);
    dm_ack = 1'b1;
    dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_ack = 1'b0;
    chk("lw_mis_data", wb_rd_data, 32'hDEAD_BEEF);
    chk("lw_mis_flag", misalign, 0);

    // LH at 0x103 reads the half at offset 2
    op(1, 0, 1, 1, 0, 3'b001, 32'h103, 0, 0, 5'd10);
    tick();
    in_valid = 1'b0;
    dm_ack = 1'b1;
    dm_rdata = 32'h8001_1234;
    tick();
    dm_ack = 1'b0;
    chk("lh_data", wb_rd_data, 32'hFFFF_8001);

    // SH at 0x102
    op(0, 1, 0, 0, 0, 3'b001, 32'h102, 0, 32'h1234_ABCD, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("sh_we", dm_we, 4'b1100);
    chk("sh_wdata", dm_wdata, 32'hABCD_0000);
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("sh_wb_valid", wb_valid, 1);

    // Timeout
    op(1, 0, 1, 1, 0, 3'b010, 32'h200, 0, 0, 5'd11);
    tick();
    in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !bus_err; i++) begin
      if (dm_req) n++;
      tick();
    end
    chk("tmo_cycles", n, 15);
    chk("tmo_bus_err", bus_err, 1);
    chk("tmo_req", dm_req, 0);
    chk("tmo_wb_valid", wb_valid, 0);
    tick();
    chk("tmo_pulse", bus_err, 0);
    chk("tmo_idle", in_ready, 1);

    // Reset during WAIT
    op(0, 1, 0, 0, 0, 3'b000, 32'h101, 0, 32'h55, 5'd0);
    tick();
    in_valid = 1'b0;
    chk("rw_we_pre", dm_we, 4'b0010);
    tick();
    rst = 1'b0;
    tick();
    chk("rw_req", dm_req, 0);
    chk("rw_we", dm_we, 0);
    chk("rw_addr", dm_addr, 0);
    chk("rw_wdata", dm_wdata, 0);
    chk("rw_wb_data", wb_rd_data, 0);
    chk("rw_in_ready", in_ready, 1);
    rst = 1'b1;
    dm_ack = 1'b1;
    tick();
    dm_ack = 1'b0;
    chk("rw_no_wb", wb_valid, 0);

    // 64-bit: LWU at 0x8
    x_in_valid = 1; x_mem_read = 1; x_reg_write = 1;
    x_mem_to_reg = 1; x_funct3 = 3'b110;
    x_alu_out = 64'h8; x_rd_addr = 5'd12;
    tick();
    x_in_valid = 0;
    chk("x_lwu_req", x_dm_req, 1);
    chk("x_lwu_addr", x_dm_addr, 32'h8);
    x_dm_ack = 1;
    x_dm_rdata = 64'h0000_0000_8000_0001;
    tick();
    x_dm_ack = 0;
    chk("x_lwu_valid", x_wb_valid, 1);
    chk("x_lwu_data", x_wb_rd_data, 64'h0000_0000_8000_0001);

    // 64-bit: LW at 0xC
    x_in_valid = 1; x_funct3 = 3'b010; x_alu_out = 64'hC;
    tick();
    x_in_valid = 0;
    chk("x_lw_addr", x_dm_addr, 32'h8);
    x_dm_ack = 1;
    x_dm_rdata = 64'h8000_0000_0000_0000;
    tick();
    x_dm_ack = 0;
    chk("x_lw_data", x_wb_rd_data, 64'hFFFF_FFFF_8000_0000);
    chk("x_lw_rd", x_wb_rd_addr, 12);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
